// File: rtl/smem_queue_store_pkg.sv
// Shared widths and token type for the curr/mem queue store.
// Pure declarations; no latency or backpressure of its own.
package smem_pkg;
    localparam int SMEM_SLOT_BITS = 2;
    localparam int SMEM_ADDR_W    = 7;
    localparam int SMEM_DATA_W    = 64;
    localparam int SMEM_NUM_W     = 9;
    localparam int SMEM_SLOTS     = 1 << SMEM_SLOT_BITS;
    localparam int SMEM_FILL_W    = SMEM_ADDR_W + 1;
    localparam int SMEM_RAM_AW    = SMEM_SLOT_BITS + SMEM_ADDR_W;

    typedef struct packed {
        logic [SMEM_DATA_W-1:0] x0;
        logic [SMEM_DATA_W-1:0] x1;
        logic [SMEM_DATA_W-1:0] x2;
        logic [SMEM_DATA_W-1:0] info;
    } token_t;

    typedef logic [SMEM_FILL_W-1:0] fill_t;

    // Only the low slot bits of a read_num pick the queue; upstream bounds reads in flight.
    function automatic logic [SMEM_RAM_AW-1:0] ram_addr(input logic [SMEM_NUM_W-1:0] num,
                                                        input logic [SMEM_ADDR_W-1:0] addr);
        return {num[SMEM_SLOT_BITS-1:0], addr};
    endfunction
endpackage

// File: rtl/smem_queue_store_if.sv
// Port bundle of the queue store: curr/mem write, curr read, drainer read, slot clear.
// Strobe-only; stall is the sole backpressure and applies to writes and the curr read.
interface smem_queue_store_if;
    import smem_pkg::*;

    logic                   stall;
    logic                   store_valid_curr;
    logic [SMEM_NUM_W-1:0]  curr_wr_num;
    logic [SMEM_ADDR_W-1:0] curr_x_addr;
    token_t                 curr_x;
    logic                   store_valid_mem;
    logic [SMEM_NUM_W-1:0]  mem_wr_num;
    logic [SMEM_ADDR_W-1:0] mem_x_addr;
    token_t                 mem_x;
    logic [SMEM_NUM_W-1:0]  rd_read_num;
    logic [SMEM_ADDR_W-1:0] rd_addr;
    token_t                 p_x;
    logic                   rd_miss;
    logic                   mem_rd_en;
    logic [SMEM_NUM_W-1:0]  mem_rd_num;
    logic [SMEM_ADDR_W-1:0] mem_rd_addr;
    logic                   mem_rd_valid;
    token_t                 mem_rd_x;
    logic                   slot_clear;
    logic [SMEM_NUM_W-1:0]  slot_clear_num;
    fill_t                  curr_fill;

    modport master (
        output stall, store_valid_curr, curr_wr_num, curr_x_addr, curr_x,
               store_valid_mem, mem_wr_num, mem_x_addr, mem_x,
               rd_read_num, rd_addr, mem_rd_en, mem_rd_num, mem_rd_addr,
               slot_clear, slot_clear_num,
        input  p_x, rd_miss, mem_rd_valid, mem_rd_x, curr_fill
    );

    modport slave (
        input  stall, store_valid_curr, curr_wr_num, curr_x_addr, curr_x,
               store_valid_mem, mem_wr_num, mem_x_addr, mem_x,
               rd_read_num, rd_addr, mem_rd_en, mem_rd_num, mem_rd_addr,
               slot_clear, slot_clear_num,
        output p_x, rd_miss, mem_rd_valid, mem_rd_x, curr_fill
    );
endinterface

// File: rtl/smem_queue_store_tok_ram.sv
// 1W1R token RAM, registered read with same-cycle write-through; 1-cycle read latency.
// No backpressure: read data register holds whenever i_re is low.
module smem_tok_ram
    import smem_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_we,
    input  logic [SMEM_RAM_AW-1:0] i_waddr,
    input  token_t                 i_wdat,
    input  logic                   i_re,
    input  logic [SMEM_RAM_AW-1:0] i_raddr,
    output token_t                 o_rdat
);
    token_t r_mem [1 << SMEM_RAM_AW];
    token_t r_rdat;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdat <= '0;
        end else if (i_re) begin
            r_rdat <= (i_we && (i_waddr == i_raddr)) ? i_wdat : r_mem[i_raddr];
        end
    end

    assign o_rdat = r_rdat;
endmodule

// File: rtl/smem_queue_store.sv
// Curr/mem token queue store with per-slot curr fill tracking; reads return 1 cycle later.
// stall blocks both writes and freezes the curr read pipe; drainer reads and slot_clear ignore it.
module smem_queue_store
    import smem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    smem_queue_store_if.slave bus
);
    logic [SMEM_SLOT_BITS-1:0] w_wr_slot, w_rd_slot, w_clr_slot;
    logic                      w_curr_we, w_mem_we, w_bypass, w_miss, w_unused;
    logic [SMEM_RAM_AW-1:0]    w_curr_waddr, w_curr_raddr, w_mem_waddr, w_mem_raddr;
    fill_t                     w_wr_fill, w_rd_fill;
    fill_t                     w_fill_nxt [SMEM_SLOTS];
    fill_t                     r_fill [SMEM_SLOTS];
    logic                      r_rd_miss, r_mem_rd_vld;

    assign w_wr_slot    = bus.curr_wr_num[SMEM_SLOT_BITS-1:0];
    assign w_rd_slot    = bus.rd_read_num[SMEM_SLOT_BITS-1:0];
    assign w_clr_slot   = bus.slot_clear_num[SMEM_SLOT_BITS-1:0];
    assign w_unused     = &{1'b0, bus.curr_wr_num[SMEM_NUM_W-1:SMEM_SLOT_BITS],
                            bus.rd_read_num[SMEM_NUM_W-1:SMEM_SLOT_BITS],
                            bus.slot_clear_num[SMEM_NUM_W-1:SMEM_SLOT_BITS]};

    assign w_curr_we    = bus.store_valid_curr && !bus.stall;
    assign w_mem_we     = bus.store_valid_mem && !bus.stall;
    assign w_curr_waddr = ram_addr(bus.curr_wr_num, bus.curr_x_addr);
    assign w_curr_raddr = ram_addr(bus.rd_read_num, bus.rd_addr);
    assign w_mem_waddr  = ram_addr(bus.mem_wr_num, bus.mem_x_addr);
    assign w_mem_raddr  = ram_addr(bus.mem_rd_num, bus.mem_rd_addr);

    // Fill is one wider than the address so a write to the last entry reads as full, not zero.
    assign w_wr_fill    = fill_t'(bus.curr_x_addr) + fill_t'(1);
    assign w_rd_fill    = r_fill[w_rd_slot];
    assign w_bypass     = w_curr_we && (w_curr_waddr == w_curr_raddr);
    assign w_miss       = !w_bypass && (fill_t'(bus.rd_addr) >= w_rd_fill);

    // Clear applies before the same-cycle write so the write re-establishes the fill.
    always_comb begin
        for (int s = 0; s < SMEM_SLOTS; s++) begin
            w_fill_nxt[s] = r_fill[s];
            if (bus.slot_clear && (w_clr_slot == SMEM_SLOT_BITS'(s))) w_fill_nxt[s] = '0;
            if (w_curr_we && (w_wr_slot == SMEM_SLOT_BITS'(s)) && (w_wr_fill > w_fill_nxt[s]))
                w_fill_nxt[s] = w_wr_fill;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SMEM_SLOTS; s++) r_fill[s] <= '0;
            r_rd_miss    <= 1'b0;
            r_mem_rd_vld <= 1'b0;
        end else begin
            for (int s = 0; s < SMEM_SLOTS; s++) r_fill[s] <= w_fill_nxt[s];
            if (!bus.stall) r_rd_miss <= w_miss;
            r_mem_rd_vld <= bus.mem_rd_en;
        end
    end

    smem_tok_ram u_curr_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_curr_we),
        .i_waddr (w_curr_waddr),
        .i_wdat  (bus.curr_x),
        .i_re    (!bus.stall),
        .i_raddr (w_curr_raddr),
        .o_rdat  (bus.p_x)
    );

    smem_tok_ram u_mem_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_mem_we),
        .i_waddr (w_mem_waddr),
        .i_wdat  (bus.mem_x),
        .i_re    (bus.mem_rd_en),
        .i_raddr (w_mem_raddr),
        .o_rdat  (bus.mem_rd_x)
    );

    assign bus.rd_miss      = r_rd_miss;
    assign bus.mem_rd_valid = r_mem_rd_vld;
    assign bus.curr_fill    = w_rd_fill;
endmodule

// File: tb/tb_smem_queue_store.sv
// Directed bench for smem_queue_store; expected read results are queued at issue
// and a monitor compares them as the DUT presents them.
module tb_smem_queue_store;
    import smem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    smem_queue_store_if bus();
    smem_queue_store dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [63:0] x0;
        logic        miss;
        bit          chkx;
        string       tag;
    } cexp_t;
    typedef struct {
        logic [63:0] info;
        string       tag;
    } mexp_t;

    cexp_t cq[$];
    mexp_t mq[$];
    cexp_t ce;
    mexp_t me;
    int    n_tests = 0;
    int    n_fail  = 0;
    bit    curr_chk_req = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Monitor: curr results are due the edge after an issued read; mem results whenever valid.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (curr_chk_req) begin
                if (cq.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL curr_sb: result due but nothing expected");
                end else begin
                    ce = cq.pop_front();
                    check({ce.tag, "_miss"}, 64'(bus.rd_miss), 64'(ce.miss));
                    if (ce.chkx) check({ce.tag, "_x0"}, bus.p_x.x0, ce.x0);
                end
            end
            if (bus.mem_rd_valid === 1'b1) begin
                if (mq.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL mem_sb: mem_rd_valid=1 with nothing expected");
                end else begin
                    me = mq.pop_front();
                    check({me.tag, "_info"}, bus.mem_rd_x.info, me.info);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic idle();
        bus.stall            = 1'b0;
        bus.store_valid_curr = 1'b0;
        bus.curr_wr_num      = '0;
        bus.curr_x_addr      = '0;
        bus.curr_x           = '0;
        bus.store_valid_mem  = 1'b0;
        bus.mem_wr_num       = '0;
        bus.mem_x_addr       = '0;
        bus.mem_x            = '0;
        bus.rd_read_num      = '0;
        bus.rd_addr          = '0;
        bus.mem_rd_en        = 1'b0;
        bus.mem_rd_num       = '0;
        bus.mem_rd_addr      = '0;
        bus.slot_clear       = 1'b0;
        bus.slot_clear_num   = '0;
        curr_chk_req         = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic cwr(input int num, input int addr, input logic [63:0] x0);
        bus.store_valid_curr = 1'b1;
        bus.curr_wr_num      = 9'(num);
        bus.curr_x_addr      = 7'(addr);
        bus.curr_x           = '{x0: x0, x1: ~x0, x2: x0 ^ 64'h1234, info: x0 + 64'd1};
    endtask

    task automatic crd(input int num, input int addr, input logic [63:0] x0,
                       input logic miss, input bit chkx, input string tag);
        cexp_t e;
        bus.rd_read_num = 9'(num);
        bus.rd_addr     = 7'(addr);
        e.x0 = x0; e.miss = miss; e.chkx = chkx; e.tag = tag;
        cq.push_back(e);
        curr_chk_req = 1'b1;
    endtask

    task automatic mwr(input int num, input int addr, input logic [63:0] info);
        bus.store_valid_mem = 1'b1;
        bus.mem_wr_num      = 9'(num);
        bus.mem_x_addr      = 7'(addr);
        bus.mem_x           = '{x0: 64'h0, x1: 64'h0, x2: 64'h0, info: info};
    endtask

    task automatic mrd(input int num, input int addr, input logic [63:0] info, input string tag);
        mexp_t e;
        bus.mem_rd_en   = 1'b1;
        bus.mem_rd_num  = 9'(num);
        bus.mem_rd_addr = 7'(addr);
        e.info = info; e.tag = tag;
        mq.push_back(e);
    endtask

    task automatic chk_fill(input int num, input int exp, input string tag);
        bus.rd_read_num = 9'(num);
        #1;
        check(tag, 64'(bus.curr_fill), 64'(exp));
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) step();
        check("rst_px0", bus.p_x.x0, 64'h0);
        check("rst_miss", 64'(bus.rd_miss), 64'h0);
        check("rst_mvld", 64'(bus.mem_rd_valid), 64'h0);
        chk_fill(0, 0, "rst_fill");
        rst = 1'b0;
        step();

        // write then read back, plus fill and miss boundary
        idle(); cwr(0, 5, 64'hA5); step();
        idle(); crd(0, 5, 64'hA5, 1'b0, 1'b1, "t1_rd"); step();
        chk_fill(0, 6, "t1_fill");
        idle(); crd(0, 6, 64'h0, 1'b1, 1'b0, "t1_edge"); step();
        idle(); crd(9'h104, 5, 64'hA5, 1'b0, 1'b1, "alias"); step();

        // same-cycle write/read bypass into an empty slot
        idle(); cwr(1, 0, 64'h11); crd(1, 0, 64'h11, 1'b0, 1'b1, "t2_byp"); step();
        chk_fill(1, 1, "t2_fill");

        // stall holds read outputs and blocks writes
        idle(); crd(0, 5, 64'hA5, 1'b0, 1'b1, "t3_pre"); step();
        for (int i = 0; i < 3; i++) begin
            idle(); bus.stall = 1'b1;
            cwr(0, (i == 2) ? 50 : 5, 64'hFF);
            crd(0, (i == 2) ? 100 : 5, 64'hA5, 1'b0, 1'b1, "t3_hold");
            step();
        end
        idle(); chk_fill(0, 6, "t3_fill");
        crd(0, 5, 64'hA5, 1'b0, 1'b1, "t3_post"); step();

        // full slot, clear, clear+write, max semantics
        idle(); cwr(2, 127, 64'h7F); step();
        idle(); chk_fill(2, 128, "t4_full");
        idle(); bus.slot_clear = 1'b1; bus.slot_clear_num = 9'h006; step();
        idle(); chk_fill(2, 0, "t4_clr");
        idle(); crd(2, 0, 64'h0, 1'b1, 1'b0, "t4_miss"); step();
        idle(); bus.slot_clear = 1'b1; bus.slot_clear_num = 9'd1; cwr(1, 3, 64'h33); step();
        idle(); chk_fill(1, 4, "t4_clrwr");
        idle(); cwr(1, 1, 64'h22); step();
        idle(); chk_fill(1, 4, "t4_max");
        chk_fill(0, 6, "t4_other");

        // drainer port
        idle(); mwr(3, 9, 64'h77); mrd(3, 9, 64'h77, "t5_byp"); step();
        idle(); mwr(3, 10, 64'h55); step();
        idle(); bus.stall = 1'b1; mwr(3, 10, 64'h99); step();
        idle(); mrd(3, 10, 64'h55, "t5_stwr"); step();
        idle(); bus.stall = 1'b1; mrd(7, 9, 64'h77, "t5_strd"); step();
        idle(); step();
        check("t5_hold", bus.mem_rd_x.info, 64'h77);

        // reset mid-operation
        idle(); crd(0, 6, 64'h0, 1'b1, 1'b0, "t6_pre"); mrd(3, 10, 64'h55, "t6_mem"); step();
        idle(); rst = 1'b1;
        #1;
        check("t6_px0", bus.p_x.x0, 64'h0);
        check("t6_miss", 64'(bus.rd_miss), 64'h0);
        check("t6_mvld", 64'(bus.mem_rd_valid), 64'h0);
        repeat (2) step();
        rst = 1'b0;
        for (int s = 0; s < 4; s++) chk_fill(s, 0, "t6_fill");
        idle(); crd(1, 0, 64'h0, 1'b1, 1'b0, "t6_post"); step();

        idle(); repeat (3) step();
        check("sb_drain", 64'(cq.size() + mq.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
